// File: rtl/utpu_pkg.sv
// Shared types and default widths for the accumulator quantizer datapath.
package utpu_pkg;

    localparam int DEF_ARRAY_SIZE  = 2;
    localparam int DEF_ACC_WIDTH   = 16;
    localparam int DEF_OUT_WIDTH   = 8;
    localparam int DEF_SHIFT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } quant_state_t;

endpackage

// File: rtl/acc_requant.sv
// Combinational requantizer for one accumulator: round, arithmetic shift,
// optional ReLU, then saturate to the output width.
module acc_requant #(
    parameter int ACC_W   = 16,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 4
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic [SHIFT_W-1:0]      shift,
    input  logic                    relu_en,
    output logic signed [OUT_W-1:0] data
);

    localparam int EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] SAT_MAX =
        $signed({{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] bias;
    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] res;

    always_comb begin
        // One extra bit keeps the rounding bias from overflowing at full scale.
        ext  = {acc[ACC_W-1], acc};
        bias = '0;
        if (shift != '0) begin
            bias = EXT_W'(1) << (shift - 1'b1);
        end
        sum = ext + bias;
        res = sum >>> shift;
        if (relu_en && (res < 0)) begin
            res = '0;
        end
        if (res > SAT_MAX) begin
            data = SAT_MAX[OUT_W-1:0];
        end else if (res < SAT_MIN) begin
            data = SAT_MIN[OUT_W-1:0];
        end else begin
            data = res[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/acc_quantizer.sv
// Captures a MAC array's accumulators on start and drains them, quantized,
// one element per valid/ready handshake.
//   state | meaning
//   IDLE  | waiting for start; capture on start
//   DRAIN | presenting element idx_q, advancing on out_ready
//   DONE  | one-cycle done pulse, then back to IDLE
module acc_quantizer
    import utpu_pkg::*;
#(
    parameter int ARRAY_SIZE             = DEF_ARRAY_SIZE,
    parameter int ACCUMULATOR_DATA_WIDTH = DEF_ACC_WIDTH,
    parameter int OUTPUT_DATA_WIDTH      = DEF_OUT_WIDTH,
    parameter int SHIFT_WIDTH            = DEF_SHIFT_WIDTH,
    localparam int IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] accumulator [ARRAY_SIZE-1:0],
    input  logic [SHIFT_WIDTH-1:0]                   shift,
    input  logic                                     relu_en,
    output logic                                     busy,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic signed [OUTPUT_DATA_WIDTH-1:0]      out_data,
    output logic [IDX_W-1:0]                         out_index,
    output logic                                     out_last,
    output logic                                     done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_SIZE - 1);

    quant_state_t state_q, state_n;

    logic signed [ACCUMULATOR_DATA_WIDTH-1:0] acc_q [ARRAY_SIZE-1:0];
    logic [SHIFT_WIDTH-1:0]                   shift_q;
    logic                                     relu_q;
    logic [IDX_W-1:0]                         idx_q;
    logic signed [OUTPUT_DATA_WIDTH-1:0]      req_data;
    logic                                     is_last;

    assign is_last = (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            relu_q  <= 1'b0;
            idx_q   <= '0;
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_n;
            if (state_q == IDLE && start) begin
                shift_q <= shift;
                relu_q  <= relu_en;
                idx_q   <= '0;
                for (int i = 0; i < ARRAY_SIZE; i++) begin
                    acc_q[i] <= accumulator[i];
                end
            end else if (state_q == DRAIN && out_ready && !is_last) begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (start) state_n = DRAIN;
            DRAIN:   if (out_ready && is_last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Single shared requantizer on the registered element; out_ready only
    // reaches the index register, never the data path.
    acc_requant #(
        .ACC_W   (ACCUMULATOR_DATA_WIDTH),
        .OUT_W   (OUTPUT_DATA_WIDTH),
        .SHIFT_W (SHIFT_WIDTH)
    ) u_requant (
        .acc     (acc_q[idx_q]),
        .shift   (shift_q),
        .relu_en (relu_q),
        .data    (req_data)
    );

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DRAIN);
    assign out_data  = out_valid ? req_data : '0;
    assign out_index = out_valid ? idx_q : '0;
    assign out_last  = out_valid && is_last;
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_acc_quantizer.sv
// Directed bench for acc_quantizer with a 2-element and a 4-element instance.
module tb_acc_quantizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ARRAY_SIZE = 2 instance
    logic              rst2, start2, relu2, ready2;
    logic signed [15:0] acc2 [1:0];
    logic [3:0]        shift2;
    logic              busy2, valid2, last2, done2;
    logic signed [7:0] data2;
    logic [0:0]        idx2;

    // ARRAY_SIZE = 4 instance
    logic              rst4, start4, relu4, ready4;
    logic signed [15:0] acc4 [3:0];
    logic [3:0]        shift4;
    logic              busy4, valid4, last4, done4;
    logic signed [7:0] data4;
    logic [1:0]        idx4;

    acc_quantizer #(.ARRAY_SIZE(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .accumulator(acc2),
        .shift(shift2), .relu_en(relu2), .busy(busy2), .out_valid(valid2),
        .out_ready(ready2), .out_data(data2), .out_index(idx2),
        .out_last(last2), .done(done2)
    );

    acc_quantizer #(.ARRAY_SIZE(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .accumulator(acc4),
        .shift(shift4), .relu_en(relu4), .busy(busy4), .out_valid(valid4),
        .out_ready(ready4), .out_data(data4), .out_index(idx4),
        .out_last(last4), .done(done4)
    );

    int xfer4 = 0;
    int dones4 = 0;
    always @(posedge clk) begin
        if (valid4 && ready4) xfer4 <= xfer4 + 1;
        if (done4) dones4 <= dones4 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle2(input string tag);
        chk({tag, "_busy"},  int'(busy2),  0);
        chk({tag, "_valid"}, int'(valid2), 0);
        chk({tag, "_data"},  int'(data2),  0);
        chk({tag, "_idx"},   int'(idx2),   0);
        chk({tag, "_last"},  int'(last2),  0);
        chk({tag, "_done"},  int'(done2),  0);
    endtask

    task automatic start2_with(input int a0, input int a1, input int sh, input bit re);
        acc2[0] = 16'(a0);
        acc2[1] = 16'(a1);
        shift2  = 4'(sh);
        relu2   = re;
        start2  = 1'b1;
        tick();
        start2  = 1'b0;
    endtask

    // Full drain with out_ready held high: element 0, element 1 (last), done, idle.
    task automatic drain2(input string tag, input int e0, input int e1);
        chk({tag, "_v0"},   int'(valid2), 1);
        chk({tag, "_d0"},   int'(data2),  e0);
        chk({tag, "_i0"},   int'(idx2),   0);
        chk({tag, "_l0"},   int'(last2),  0);
        chk({tag, "_b0"},   int'(busy2),  1);
        tick();
        chk({tag, "_v1"},   int'(valid2), 1);
        chk({tag, "_d1"},   int'(data2),  e1);
        chk({tag, "_i1"},   int'(idx2),   1);
        chk({tag, "_l1"},   int'(last2),  1);
        tick();
        chk({tag, "_done"}, int'(done2),  1);
        chk({tag, "_vD"},   int'(valid2), 0);
        chk({tag, "_dD"},   int'(data2),  0);
        tick();
        chk({tag, "_done_off"}, int'(done2), 0);
        chk({tag, "_idle"},     int'(busy2), 0);
    endtask

    initial begin
        rst2 = 1'b1; start2 = 1'b0; relu2 = 1'b0; ready2 = 1'b1; shift2 = '0;
        acc2[0] = '0; acc2[1] = '0;
        rst4 = 1'b1; start4 = 1'b0; relu4 = 1'b0; ready4 = 1'b1; shift4 = '0;
        for (int i = 0; i < 4; i++) acc4[i] = '0;
        tick();
        tick();
        rst2 = 1'b0;
        rst4 = 1'b0;
        chk_idle2("reset");
        chk("reset_busy4", int'(busy4), 0);

        // Rounded shift, with and without ReLU
        start2_with(300, -5, 2, 1'b0);
        drain2("basic", 75, -1);
        start2_with(300, -5, 2, 1'b1);
        drain2("relu", 75, 0);

        // Saturation at both rails and rounding overflow into the extra bit
        start2_with(32767, -32768, 0, 1'b0);
        drain2("sat", 127, -128);
        start2_with(32767, 0, 1, 1'b0);
        drain2("round17", 127, 0);

        // start during DRAIN must not recapture
        ready2 = 1'b0;
        start2_with(300, -5, 2, 1'b0);
        start2_with(100, 100, 0, 1'b1);
        chk("midstart_d0", int'(data2), 75);
        chk("midstart_i0", int'(idx2),  0);
        ready2 = 1'b1;
        drain2("midstart", 75, -1);

        // Reset after the first transfer aborts without done
        start2_with(300, -5, 2, 1'b0);
        tick();
        chk("abort_i1", int'(idx2), 1);
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        chk_idle2("abort");
        tick();
        chk("abort_no_done", int'(done2), 0);
        start2_with(-400, 1000, 3, 1'b0);
        drain2("post_rst", -50, 125);

        // ARRAY_SIZE=4 with a 3-cycle stall on index 1
        acc4[0] = 16'sd10; acc4[1] = 16'sd20; acc4[2] = 16'sd30; acc4[3] = -16'sd7;
        shift4 = 4'd1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("a4_d0", int'(data4), 5);
        chk("a4_i0", int'(idx4),  0);
        tick();
        ready4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("a4_stall_d", int'(data4),  10);
            chk("a4_stall_i", int'(idx4),   1);
            chk("a4_stall_l", int'(last4),  0);
            chk("a4_stall_v", int'(valid4), 1);
            tick();
        end
        chk("a4_after_stall_i", int'(idx4), 1);
        ready4 = 1'b1;
        tick();
        chk("a4_d2", int'(data4), 15);
        chk("a4_i2", int'(idx4),  2);
        tick();
        chk("a4_d3", int'(data4), -3);
        chk("a4_l3", int'(last4), 1);
        tick();
        chk("a4_done", int'(done4), 1);
        tick();
        tick();
        chk("a4_xfers", xfer4,  4);
        chk("a4_dones", dones4, 1);
        chk("a4_idle",  int'(busy4), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
